net_bus_packer: RTL and testbench
=================================

# net_bus_packer

Byte-stream to NetBus flit packer sitting directly upstream of the two-port NetBus mux's write port (WDATA/WVALID/WREADY). It collects an 8-bit packet stream with an end-of-packet marker and a per-packet destination. It emits NetBus flits of DATA_WIDTH*9+14 bits, one flit per DATA_WIDTH bytes, with a partial final flit. Single clock domain; the mux's own Tx side handles any fan-out.

## Interface
Parameters:
- DATA_WIDTH, 4: byte lanes per flit; range 1..8.
- DEST_WIDTH, 8: destination field width; fixed layout requires 8.

Ports:
- CLK  in  1  sole clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN_DATA  in  8  payload byte.
- IN_DEST  in  8  destination; sampled only with the first byte of a packet.
- IN_LAST  in  1  byte is the final byte of the packet.
- IN_VALID  in  1  byte valid.
- IN_READY  out  1  byte accepted when IN_VALID & IN_READY.
- WDATA  out  DATA_WIDTH*9+14  flit to mux WDATA.
- WVALID  out  1  flit valid.
- WREADY  in  1  flit accepted when WVALID & WREADY.
- PKT_COUNT  out  16  packets fully emitted; wraps 0xFFFF -> 0x0000.

## Operation
Flit layout:
- [7:0] destination.
- [8] SOP.
- [9] EOP.
- [13:10] zero.
- Lane k occupies [14+9k +: 9]: bit 8 is lane-valid, bits 7:0 are the byte.
- Byte order: first byte of a flit goes in lane 0. Unused lanes are all-zero.

Assembly register (ASM):
- Holds the lane array, a lane index LIDX, a latched DEST and a pending-SOP flag.
- ASM is "closed" when LIDX == DATA_WIDTH or the last accepted byte had IN_LAST.

Packet state machine:
- IDLE: no packet open. An accepted byte latches IN_DEST, sets pending-SOP and goes to OPEN.
- OPEN: accepted bytes fill lane LIDX and increment LIDX.
- An accepted byte with IN_LAST closes ASM with EOP and returns to IDLE.
- Every packet carries at least one byte; empty packets cannot be expressed.

Transfer from ASM to output register:
- Occurs when ASM is closed and (!WVALID | WREADY).
- Copies the lanes, DEST, SOP = pending-SOP and EOP = closed-by-last into the output register, and sets WVALID.
- Clears pending-SOP and resets LIDX to 0.
- The latched DEST persists for the remaining flits of the packet.

Flow control:
- IN_READY = !closed | !WVALID | WREADY (combinational).
- A byte accepted in a transfer cycle lands in lane 0 of the freshly cleared ASM.
- A transfer and a new byte in the same cycle: the new byte starts the next flit. If the transfer carried EOP, that byte is the first byte of a new packet: latch DEST, set SOP.
- WVALID clears on WVALID & WREADY when no transfer happens that cycle.
- WDATA is held stable while WVALID & !WREADY.

Counter:
- PKT_COUNT increments on each accepted output flit (WVALID & WREADY) with EOP = 1.

## Timing
Reset (RESET high at a rising edge):
- WVALID = 0, WDATA = 0, PKT_COUNT = 0, LIDX = 0, state IDLE, pending-SOP = 0.
- IN_READY = 1 from the first cycle after reset.
- Reset mid-packet discards the partial ASM and the output flit without emission.

Latency:
- WVALID rises on the edge after the edge that accepted the closing byte, provided the output register is free or being drained.

Throughput:
- 1 byte/cycle sustained with WREADY held high; no bubbles between flits or packets.

Backpressure:
- With WREADY low and ASM closed, IN_READY = 0. Exactly one flit is buffered in ASM plus one in the output register.

Lane-count boundaries:
- A packet of exactly N*DATA_WIDTH bytes gives N full flits; the last has EOP.
- DATA_WIDTH = 1 gives one flit per byte.

## Test plan
- Reset then a 4-byte packet (DEST 0x5A, bytes 11 22 33 44, DATA_WIDTH = 4), WREADY = 1 -> one flit: SOP = 1, EOP = 1, dest 0x5A, all lanes valid. WVALID high the cycle after byte 44 is accepted. PKT_COUNT = 1.
- 6-byte packet (01..06, DEST 0x03) -> flit 1: SOP, lanes 01..04, EOP = 0. Flit 2: SOP = 0, EOP = 1, dest 0x03, lanes 05 06 valid, lanes 2-3 = 0.
- Back-to-back 1-byte packets (AA dest 0x10, BB dest 0x20) on consecutive cycles, WREADY = 1 -> two flits on consecutive cycles, each SOP = EOP = 1, correct dests. IN_READY never drops.
- WREADY = 0 during a 12-byte packet -> IN_READY falls after 8 bytes accepted. WDATA stays stable. Releasing WREADY yields 3 flits in order with no loss or duplication.
- RESET asserted after 3 bytes of a packet -> no flit emitted. PKT_COUNT = 0. The next 2-byte packet emits with SOP = 1 and lanes 0-1 only.
- Force PKT_COUNT to 0xFFFF via 65535 single-byte packets, then send one more -> PKT_COUNT = 0x0000.

Source files
------------

// File: rtl/net_bus_packer.sv
// Byte-stream to NetBus flit packer: gathers up to DATA_WIDTH bytes per flit
// in an assembly register, then hands each closed flit to a single output register.
module net_bus_packer #(
  parameter int DATA_WIDTH = 4,
  parameter int DEST_WIDTH = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [7:0]                 IN_DATA,
  input  logic [DEST_WIDTH-1:0]      IN_DEST,
  input  logic                       IN_LAST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  output logic [DATA_WIDTH*9+13:0]   WDATA,
  output logic                       WVALID,
  input  logic                       WREADY,
  output logic [15:0]                PKT_COUNT
);

  localparam int LW = $clog2(DATA_WIDTH + 1);

  typedef enum logic { S_IDLE, S_OPEN } state_t;

  // Handshakes: a byte moves on IN_VALID & IN_READY, a flit moves on
  // WVALID & WREADY; neither side may make valid depend on ready.
  state_t                    state;
  logic [DATA_WIDTH*9-1:0]   lanes;
  logic [LW-1:0]             lidx;
  logic [DEST_WIDTH-1:0]     dest_q;
  logic                      sop_pend;
  logic                      eop_pend;
  logic [DATA_WIDTH*9+13:0]  wdata_q;
  logic                      wvalid_q;
  logic [15:0]               pkt_cnt;

  logic                      closed;
  logic                      xfer;
  logic                      accept;
  logic [DATA_WIDTH*9-1:0]   base_lanes;
  logic [LW-1:0]             base_lidx;
  logic [DATA_WIDTH*9-1:0]   lanes_nxt;

  assign closed   = (lidx == LW'(DATA_WIDTH)) | eop_pend;
  assign xfer     = closed & (!wvalid_q | WREADY);
  assign IN_READY = !closed | !wvalid_q | WREADY;
  assign accept   = IN_VALID & IN_READY;

  // A transfer empties the assembly register first, so a byte taken in the
  // same cycle lands in lane 0 of the next flit.
  always_comb begin
    base_lanes = xfer ? '0 : lanes;
    base_lidx  = xfer ? '0 : lidx;
    lanes_nxt  = base_lanes;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      if (accept && (base_lidx == LW'(k))) begin
        lanes_nxt[k*9 +: 9] = {1'b1, IN_DATA};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= S_IDLE;
      lanes    <= '0;
      lidx     <= '0;
      dest_q   <= '0;
      sop_pend <= 1'b0;
      eop_pend <= 1'b0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      pkt_cnt  <= '0;
    end else begin
      if (wvalid_q && WREADY && wdata_q[9]) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end

      if (xfer) begin
        wdata_q  <= {lanes, 4'b0000, eop_pend, sop_pend, dest_q};
        wvalid_q <= 1'b1;
      end else if (wvalid_q && WREADY) begin
        wvalid_q <= 1'b0;
      end

      lanes <= lanes_nxt;
      if (xfer) begin
        lidx     <= '0;
        sop_pend <= 1'b0;
        eop_pend <= 1'b0;
      end

      // Later assignments override the transfer clears above.
      if (accept) begin
        lidx     <= base_lidx + LW'(1);
        eop_pend <= IN_LAST;
        if (state == S_IDLE) begin
          dest_q   <= IN_DEST;
          sop_pend <= 1'b1;
        end
        state <= IN_LAST ? S_IDLE : S_OPEN;
      end
    end
  end

  assign WDATA     = wdata_q;
  assign WVALID    = wvalid_q;
  assign PKT_COUNT = pkt_cnt;

endmodule

// File: tb/tb_net_bus_packer.sv
// Bench for net_bus_packer: packets are chunked into expected flits by a
// queue-based model; a negedge monitor scores every accepted flit.
module tb_net_bus_packer;

  localparam int DW = 4;
  localparam int FW = DW*9 + 14;

  logic          CLK;
  logic          RESET;
  logic [7:0]    IN_DATA;
  logic [7:0]    IN_DEST;
  logic          IN_LAST;
  logic          IN_VALID;
  logic          IN_READY;
  logic [FW-1:0] WDATA;
  logic          WVALID;
  logic          WREADY;
  logic [15:0]   PKT_COUNT;

  net_bus_packer #(.DATA_WIDTH(DW), .DEST_WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .IN_DATA(IN_DATA), .IN_DEST(IN_DEST), .IN_LAST(IN_LAST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .PKT_COUNT(PKT_COUNT)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [FW-1:0] exp_q[$];
  logic [15:0]   exp_cnt = '0;
  int            exp_total = 0;
  int            flits_seen = 0;
  int            acc_count = 0;
  bit            rdy_force = 1'b1;
  logic          rdy_val = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: split a packet into DW-byte chunks
  function automatic void model_pkt(input logic [7:0] dest, input logic [7:0] b[$]);
    int n;
    logic [FW-1:0] f;
    n = b.size();
    for (int c = 0; c < n; c += DW) begin
      f = '0;
      f[7:0] = dest;
      f[8]   = (c == 0);
      f[9]   = (c + DW >= n);
      for (int k = 0; k < DW && c + k < n; k++) f[14+9*k +: 9] = {1'b1, b[c+k]};
      exp_q.push_back(f);
      exp_total++;
    end
  endfunction

  always @(posedge CLK) begin
    #1;
    WREADY = rdy_force ? rdy_val : logic'($urandom_range(0, 1));
  end

  // scoreboard monitor
  logic [FW-1:0] held;
  bit            hold_v = 1'b0;
  always @(negedge CLK) begin
    logic [FW-1:0] f;
    if (RESET) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && WVALID) check("wdata_stable", WDATA, held);
      hold_v = WVALID && !WREADY;
      held   = WDATA;
      if (WVALID && WREADY) begin
        flits_seen++;
        if (exp_q.size() == 0) begin
          check("flit_excess", flits_seen, exp_total);
        end else begin
          f = exp_q.pop_front();
          check("flit", WDATA, f);
          if (f[9]) exp_cnt++;
        end
      end
    end
  end

  // driver tasks
  task automatic drive_byte(input logic [7:0] d, input logic [7:0] dest, input logic last,
                            output int waits);
    logic acc;
    IN_VALID = 1'b1; IN_DATA = d; IN_DEST = dest; IN_LAST = last;
    waits = 0;
    forever begin
      @(negedge CLK);
      acc = IN_READY;
      @(posedge CLK); #1;
      if (acc) break;
      waits++;
      if (waits > 200) begin
        check("accept_timeout", waits, 0);
        break;
      end
    end
    acc_count++;
    IN_VALID = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] dest, input logic [7:0] b[$], input int gap_max,
                          output int max_wait);
    int w;
    max_wait = 0;
    model_pkt(dest, b);
    for (int i = 0; i < b.size(); i++) begin
      drive_byte(b[i], (i == 0) ? dest : 8'($urandom), (i == b.size() - 1), w);
      if (w > max_wait) max_wait = w;
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge CLK); #1; end
    end
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while ((exp_q.size() != 0 || WVALID) && cyc < 1000) begin
      @(posedge CLK); #1;
      cyc++;
    end
    check({tag, "_drain_left"}, exp_q.size(), 0);
    check({tag, "_pkt_count"}, PKT_COUNT, exp_cnt);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    exp_q.delete();
    exp_cnt = '0; exp_total = 0; flits_seen = 0;
  endtask

  initial begin
    logic [7:0] b[$];
    int w;
    RESET = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; IN_DEST = '0; IN_LAST = 1'b0; WREADY = 1'b1;
    @(posedge CLK); #1;
    do_reset();
    check("rst_wvalid", WVALID, 0);
    check("rst_wdata", WDATA, 0);
    check("rst_pkt_count", PKT_COUNT, 0);
    check("rst_in_ready", IN_READY, 1);

    // single full flit and its latency
    b = {8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(8'h5A, b, 0, w);
    check("lat_before", WVALID, 0);
    @(posedge CLK); #1;
    check("lat_rise", WVALID, 1);
    drain("p4");
    check("p4_count_one", PKT_COUNT, 16'd1);

    // two-flit packet with partial tail
    b = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_pkt(8'h03, b, 0, w);
    drain("p6");

    // back-to-back single-byte packets
    b = {8'hAA};
    send_pkt(8'h10, b, 0, w);
    check("b2b_wait_a", w, 0);
    b = {8'hBB};
    send_pkt(8'h20, b, 0, w);
    check("b2b_wait_b", w, 0);
    check("b2b_wvalid_a", WVALID, 1);
    @(posedge CLK); #1;
    check("b2b_wvalid_b", WVALID, 1);
    drain("b2b");

    // backpressure during a 12-byte packet
    rdy_val = 1'b0;
    @(posedge CLK); #1;
    acc_count = 0;
    b = {};
    for (int i = 0; i < 12; i++) b.push_back(8'($urandom));
    fork
      send_pkt(8'hC3, b, 0, w);
      begin
        repeat (30) @(posedge CLK);
        @(negedge CLK);
        check("bp_accepted", acc_count, 8);
        check("bp_in_ready", IN_READY, 0);
        check("bp_wvalid", WVALID, 1);
        rdy_val = 1'b1;
      end
    join
    drain("bp");

    // reset in the middle of a packet
    drive_byte(8'h91, 8'h77, 1'b0, w);
    drive_byte(8'h92, 8'h77, 1'b0, w);
    drive_byte(8'h93, 8'h77, 1'b0, w);
    do_reset();
    check("midrst_pkt_count", PKT_COUNT, 0);
    check("midrst_wvalid", WVALID, 0);
    b = {8'hE1, 8'hE2};
    send_pkt(8'h42, b, 0, w);
    drain("midrst");
    check("midrst_flits", flits_seen, 1);

    // randomized packets with random backpressure and gaps
    rdy_force = 1'b0;
    for (int p = 0; p < 40; p++) begin
      b = {};
      repeat ($urandom_range(1, 11)) b.push_back(8'($urandom));
      send_pkt(8'($urandom), b, $urandom_range(0, 2), w);
    end
    rdy_force = 1'b1; rdy_val = 1'b1;
    drain("rand");
    check("rand_flits", flits_seen, exp_total);

    // packet counter wrap
    do_reset();
    b = {8'h5C};
    for (int p = 0; p < 65535; p++) send_pkt(8'($urandom), b, 0, w);
    drain("wrap_pre");
    check("wrap_ffff", PKT_COUNT, 16'hFFFF);
    send_pkt(8'h01, b, 0, w);
    drain("wrap_post");
    check("wrap_zero", PKT_COUNT, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
